viterbi_dec_param: RTL and testbench

VITERBI_DEC_PARAM -- requirements
Module: viterbi_dec_param

---
 rtl/viterbi_dec_param.sv | 175 +++++++++++++++++
 tb/tb_viterbi_dec_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_dec_param.sv
// Hard-decision Viterbi decoder for a rate-1/2, K=3 convolutional code.
// Register-exchange survivors; one block of BLOCK_LEN steps is decoded, then streamed out oldest bit first.
module viterbi_dec_param #(
  parameter int unsigned BLOCK_LEN  = 7,
  parameter logic [2:0]  G0         = 3'b111,
  parameter logic [2:0]  G1         = 3'b101,
  parameter int unsigned METRIC_W   = 6,
  parameter bit          TERMINATED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [1:0]          in_sym,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic                out_last,
  output logic [METRIC_W-1:0] path_metric
);

  localparam int unsigned      CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACS, DECIDE, OUTPUT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic [CNT_W-1:0]      oidx_q, oidx_d;
  logic [METRIC_W-1:0]   metric_q [4];
  logic [METRIC_W-1:0]   metric_d [4];
  logic [BLOCK_LEN-1:0]  path_q [4];
  logic [BLOCK_LEN-1:0]  path_d [4];
  logic [BLOCK_LEN-1:0]  opath_q, opath_d;
  logic [METRIC_W-1:0]   ometric_q, ometric_d;

  logic [METRIC_W-1:0]   m_cur [4];
  logic [BLOCK_LEN-1:0]  p_cur [4];
  logic [METRIC_W-1:0]   m_acs [4];
  logic [BLOCK_LEN-1:0]  p_acs [4];
  logic [1:0]            ns_b, pw, sel;
  logic [METRIC_W-1:0]   cand0, cand1;

  function automatic logic [1:0] branch_metric(input logic [2:0] r, input logic [1:0] sym);
    logic [1:0] e;
    e = {^(G0 & r), ^(G1 & r)} ^ sym;
    return {1'b0, e[1]} + {1'b0, e[0]};
  endfunction

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a, input logic [1:0] b);
    logic [METRIC_W:0] s;
    s = {1'b0, a} + (METRIC_W + 1)'(b);
    return s[METRIC_W] ? '1 : s[METRIC_W-1:0];
  endfunction

  assign in_ready    = (state_q == IDLE) || (state_q == ACS);
  assign out_valid   = (state_q == OUTPUT);
  assign out_bit     = opath_q[oidx_q];
  assign out_last    = out_valid && (oidx_q == LAST);
  assign path_metric = ometric_q;

  // In IDLE the ACS runs from the block-start metrics so the first symbol is step 0.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (state_q == IDLE) begin
        m_cur[i] = (i == 0) ? '0 : '1;
        p_cur[i] = '0;
      end else begin
        m_cur[i] = metric_q[i];
        p_cur[i] = path_q[i];
      end
    end
  end

  always_comb begin
    ns_b  = '0;
    pw    = '0;
    cand0 = '0;
    cand1 = '0;
    for (int unsigned ns = 0; ns < 4; ns++) begin
      ns_b  = 2'(ns);
      cand0 = sat_add(m_cur[{ns_b[0], 1'b0}], branch_metric({ns_b, 1'b0}, in_sym));
      cand1 = sat_add(m_cur[{ns_b[0], 1'b1}], branch_metric({ns_b, 1'b1}, in_sym));
      if (cand0 <= cand1) begin
        pw           = {ns_b[0], 1'b0};
        m_acs[ns_b]  = cand0;
      end else begin
        pw           = {ns_b[0], 1'b1};
        m_acs[ns_b]  = cand1;
      end
      p_acs[ns_b]         = p_cur[pw];
      p_acs[ns_b][step_q] = ns_b[1];
    end
  end

  always_comb begin
    sel = '0;
    if (!TERMINATED) begin
      for (int unsigned i = 1; i < 4; i++) begin
        if (metric_q[2'(i)] < metric_q[sel]) sel = 2'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    oidx_d    = oidx_q;
    metric_d  = metric_q;
    path_d    = path_q;
    opath_d   = opath_q;
    ometric_d = ometric_q;
    case (state_q)
      IDLE: begin
        metric_d = m_cur;
        path_d   = p_cur;
        step_d   = '0;
        if (in_valid) begin
          metric_d = m_acs;
          path_d   = p_acs;
          step_d   = CNT_W'(1);
          state_d  = ACS;
        end
      end
      ACS: begin
        if (in_valid) begin
          metric_d = m_acs;
          path_d   = p_acs;
          if (step_q == LAST) begin
            step_d  = '0;
            state_d = DECIDE;
          end else begin
            step_d = step_q + CNT_W'(1);
          end
        end
      end
      DECIDE: begin
        opath_d   = path_q[sel];
        ometric_d = metric_q[sel];
        oidx_d    = '0;
        state_d   = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          if (oidx_q == LAST) state_d = IDLE;
          else                oidx_d  = oidx_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      oidx_q    <= '0;
      opath_q   <= '0;
      ometric_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        metric_q[i] <= (i == 0) ? '0 : '1;
        path_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      oidx_q    <= oidx_d;
      opath_q   <= opath_d;
      ometric_q <= ometric_d;
      metric_q  <= metric_d;
      path_q    <= path_d;
    end
  end

endmodule

// File: tb/tb_viterbi_dec_param.sv
// Scoreboard bench: default decoder (A) plus a 3-bit-metric, 16-step decoder (B) for saturation.
module tb_viterbi_dec_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid_a, in_valid_b;
  logic [1:0] in_sym_a, in_sym_b;
  logic       in_ready_a, in_ready_b;
  logic       out_valid_a, out_valid_b;
  logic       out_ready_a, out_ready_b;
  logic       out_bit_a, out_bit_b;
  logic       out_last_a, out_last_b;
  logic [5:0] path_metric_a;
  logic [2:0] path_metric_b;

  always #5 clk = ~clk;

  viterbi_dec_param dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_sym(in_sym_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_bit(out_bit_a), .out_last(out_last_a),
    .path_metric(path_metric_a)
  );

  viterbi_dec_param #(.BLOCK_LEN(16), .METRIC_W(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_sym(in_sym_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_bit(out_bit_b), .out_last(out_last_b),
    .path_metric(path_metric_b)
  );

  typedef struct { bit b; bit l; int m; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int total = 0;
  int bad   = 0;
  bit bp_en = 1'b0;

  logic [1:0] clean_syms [7] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
  bit         clean_bits [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backpressure pattern: out_ready alternates when enabled, otherwise held high.
  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready_a = ~out_ready_a;
    else       out_ready_a = 1'b1;
  end

  bit   hold_a = 1'b0;
  logic hb_a, hl_a;
  int   hm_a;

  always @(negedge clk) begin
    exp_t e;
    if (hold_a) begin
      chk("hold_valid", int'(out_valid_a), 1);
      chk("hold_bit", int'(out_bit_a), int'(hb_a));
      chk("hold_last", int'(out_last_a), int'(hl_a));
      chk("hold_metric", int'(path_metric_a), hm_a);
    end
    hold_a = 1'b0;
    if (reset && out_valid_a) begin
      if (out_ready_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_output", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_bit", int'(out_bit_a), int'(e.b));
          chk("a_last", int'(out_last_a), int'(e.l));
          chk("a_metric", int'(path_metric_a), e.m);
        end
      end else begin
        hold_a = 1'b1;
        hb_a   = out_bit_a;
        hl_a   = out_last_a;
        hm_a   = int'(path_metric_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_output", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_bit", int'(out_bit_b), int'(e.b));
        chk("b_last", int'(out_last_b), int'(e.l));
        chk("b_metric", int'(path_metric_b), e.m);
      end
    end
  end

  task automatic push_clean(input int metric);
    for (int i = 0; i < 7; i++) qa.push_back('{b: clean_bits[i], l: (i == 6), m: metric});
  endtask

  task automatic put(input bit sel, input logic [1:0] s, output int waits);
    waits = 0;
    if (sel) begin in_valid_b = 1'b1; in_sym_b = s; end
    else     begin in_valid_a = 1'b1; in_sym_a = s; end
    forever begin
      @(negedge clk);
      if (sel ? in_ready_b : in_ready_a) break;
      waits++;
      if (waits > 100) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(sel ? "b_drain_left" : "a_drain_left", sel ? qb.size() : qa.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_bit", int'(out_bit_a), 0);
    chk("rst_out_last", int'(out_last_a), 0);
    chk("rst_path_metric", int'(path_metric_a), 0);
  endtask

  // Independent reference: saturating 3-bit Viterbi with stored decisions and traceback from state 0.
  task automatic model_b(input logic [1:0] s [16], output bit bits [16], output int metric);
    int m [4];
    int nm [4];
    bit dec [16][4];
    int cd [2];
    int st, pred, bm;
    logic [2:0] r;
    logic c0, c1;
    m = '{0, 7, 7, 7};
    for (int t = 0; t < 16; t++) begin
      for (int ns = 0; ns < 4; ns++) begin
        for (int b0 = 0; b0 < 2; b0++) begin
          r    = 3'(((ns >> 1) << 2) | ((ns & 1) << 1) | b0);
          c0   = ^(r & 3'b111);
          c1   = ^(r & 3'b101);
          bm   = int'(c0 != s[t][1]) + int'(c1 != s[t][0]);
          pred = ((ns & 1) << 1) | b0;
          cd[b0] = m[pred] + bm;
          if (cd[b0] > 7) cd[b0] = 7;
        end
        dec[t][ns] = (cd[1] < cd[0]);
        nm[ns]     = dec[t][ns] ? cd[1] : cd[0];
      end
      m = nm;
    end
    st = 0;
    for (int t = 15; t >= 0; t--) begin
      bits[t] = bit'((st >> 1) & 1);
      st = ((st & 1) << 1) | int'(dec[t][st]);
    end
    metric = m[0];
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    logic [1:0] err_syms [7];
    logic [1:0] sat_syms [16];
    bit         sat_bits [16];
    int         sat_metric;

    reset = 1'b0;
    in_valid_a = 1'b0; in_sym_a = 2'b00;
    in_valid_b = 1'b0; in_sym_b = 2'b00;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1 reset = 1'b1;

    // clean block, plus DECIDE/OUTPUT latency after the final symbol
    push_clean(0);
    for (int i = 0; i < 7; i++) put(1'b0, clean_syms[i], w);
    @(negedge clk);
    chk("lat_decide_valid", int'(out_valid_a), 0);
    @(negedge clk);
    chk("lat_output_valid", int'(out_valid_a), 1);
    drain(1'b0);

    // single bit error on symbol index 2
    err_syms = clean_syms;
    err_syms[2] = 2'b01;
    push_clean(1);
    for (int i = 0; i < 7; i++) put(1'b0, err_syms[i], w);
    drain(1'b0);

    // input stalls and output backpressure
    bp_en = 1'b1;
    push_clean(0);
    for (int i = 0; i < 7; i++) begin
      put(1'b0, clean_syms[i], w);
      @(posedge clk);
      #1;
    end
    drain(1'b0);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset after 4 symbols: aborted block must produce nothing
    for (int i = 0; i < 4; i++) put(1'b0, clean_syms[i], w);
    reset = 1'b0;
    @(negedge clk);
    reset_checks();
    @(posedge clk);
    #1 reset = 1'b1;
    push_clean(0);
    for (int i = 0; i < 7; i++) put(1'b0, clean_syms[i], w);
    drain(1'b0);

    // back-to-back blocks with in_valid held high
    push_clean(0);
    push_clean(0);
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 7; i++) begin
        put(1'b0, clean_syms[i], w);
        if (blk == 1 && i == 0) chk("b2b_ready_low_cycles", w, 8);
      end
    end
    drain(1'b0);

    // saturation: 3-bit metrics, all symbols inverted from the all-zero codeword
    for (int i = 0; i < 16; i++) sat_syms[i] = 2'b11;
    model_b(sat_syms, sat_bits, sat_metric);
    for (int i = 0; i < 16; i++) qb.push_back('{b: sat_bits[i], l: (i == 15), m: sat_metric});
    for (int i = 0; i < 16; i++) put(1'b1, sat_syms[i], w);
    drain(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
